// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared opcodes, ULA/write-back selects, FSM states and strobe bundle for the nRISC control
package nrisc_pkg;
  localparam logic [2:0] OP_ARITH  = 3'b000;
  localparam logic [2:0] OP_ADDI   = 3'b001;
  localparam logic [2:0] OP_LW     = 3'b010;
  localparam logic [2:0] OP_SW     = 3'b011;
  localparam logic [2:0] OP_BNEZ   = 3'b100;
  localparam logic [2:0] OP_SETVAL = 3'b101;
  localparam logic [2:0] OP_SLT    = 3'b110;
  localparam logic [2:0] OP_SYS    = 3'b111;
  localparam logic [1:0] ULAOP_ADD = 2'b00;
  localparam logic [1:0] ULAOP_SUB = 2'b01;
  localparam logic [1:0] ULAOP_SLT = 2'b10;
  localparam logic [1:0] REG1SRC_ULA = 2'b00;
  localparam logic [1:0] REG1SRC_IMM = 2'b01;
  localparam logic [1:0] REG1SRC_MEM = 2'b10;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] reg1src;
    logic       jump;
    logic       bnez;
    logic       ulasrc;
    logic [1:0] ulaop;
    logic       mem_write;
    logic       mem_load;
    logic       reg_write;
    logic       halted;
    logic       trap;
  } ctrl_t;
endpackage

// File: rtl/controle_decode.sv
// controle_decode: combinational strobes and next state from (state, opCode, funct)
module controle_decode
  import nrisc_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                funct,
  output ctrl_t               ctrl,
  output state_t              nxt,
  output logic                gated
);
  logic [2:0] op;
  logic       illegal, alu, mem;
  logic [1:0] ula_op;
  logic       ula_src;
  assign op      = opCode[2:0];
  assign illegal = (opCode >> 3) != '0;
  assign alu     = op == OP_ARITH || op == OP_ADDI || op == OP_SLT;
  assign mem     = op == OP_LW || op == OP_SW;
  assign ula_op  = op == OP_ARITH ? (funct ? ULAOP_SUB : ULAOP_ADD) : op == OP_SLT ? ULAOP_SLT : ULAOP_ADD;
  assign ula_src = op == OP_ADDI || mem;
  // gated marks states that only advance on an event (memReady in MEM, resume in HALT)
  always_comb begin
    ctrl  = '0;
    nxt   = FETCH;
    gated = 1'b0;
    case (state)
      FETCH: begin
        ctrl.ir_write = 1'b1;
        nxt = DECODE;
      end
      DECODE: nxt = illegal ? TRAP : op == OP_SETVAL ? WB : (op == OP_SYS && funct) ? HALT : EXEC;
      EXEC: begin
        if (alu || mem) begin
          ctrl.ulaop  = ula_op;
          ctrl.ulasrc = ula_src;
        end
        ctrl.bnez     = op == OP_BNEZ;
        ctrl.jump     = op == OP_SYS;
        ctrl.pc_write = op == OP_BNEZ || op == OP_SYS;
        nxt = mem ? MEM : (op == OP_BNEZ || op == OP_SYS) ? FETCH : WB;
      end
      MEM: begin
        ctrl.mem_load  = op == OP_LW;
        ctrl.mem_write = op == OP_SW;
        ctrl.pc_write  = op == OP_SW;
        gated = 1'b1;
        nxt = op == OP_LW ? WB : FETCH;
      end
      WB: begin
        if (alu || op == OP_LW) begin
          ctrl.ulaop  = ula_op;
          ctrl.ulasrc = ula_src;
        end
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.reg1src   = op == OP_LW ? REG1SRC_MEM : op == OP_SETVAL ? REG1SRC_IMM : REG1SRC_ULA;
      end
      HALT: begin
        ctrl.halted   = 1'b1;
        ctrl.pc_write = 1'b1;
        gated = 1'b1;
      end
      TRAP: begin
        ctrl.trap = 1'b1;
        nxt = TRAP;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle nRISC control FSM with memory-ready timeout, halt/resume and illegal-opcode trap
module controle_multiciclo
  import nrisc_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int ULAOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                funct,
  input  logic                memReady,
  input  logic                resume,
  output logic                IrWrite,
  output logic                PcWrite,
  output logic [1:0]          Reg1src,
  output logic                Jump,
  output logic                Bnez,
  output logic                ULAsrc,
  output logic [ULAOP_W-1:0]  ULAop,
  output logic                MemWrite,
  output logic                MemLoad,
  output logic                RegWrite,
  output logic                Halted,
  output logic                Trap
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t        state, nxt;
  ctrl_t         c;
  logic          gated, go, tmo, run;
  logic [CW-1:0] cnt;
  controle_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .state (state),
    .opCode(opCode),
    .funct (funct),
    .ctrl  (c),
    .nxt   (nxt),
    .gated (gated)
  );
  assign go  = !gated || (state == MEM ? memReady : resume);
  assign tmo = MEM_TIMEOUT > 0 && state == MEM && !memReady && int'(cnt) + 1 >= MEM_TIMEOUT;
  // run holds FETCH idle for the reset-release edge so all strobes stay 0 until FETCH is entered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= tmo ? TRAP : go ? nxt : state;
      cnt <= (run && state == MEM && !memReady) ? (&cnt ? cnt : cnt + 1'b1) : '0;
    end
  end
  assign IrWrite  = run & c.ir_write;
  assign PcWrite  = run & c.pc_write & go;
  assign Reg1src  = run ? c.reg1src : '0;
  assign Jump     = run & c.jump;
  assign Bnez     = run & c.bnez;
  assign ULAsrc   = run & c.ulasrc;
  assign ULAop    = run ? ULAOP_W'(c.ulaop) : '0;
  assign MemWrite = run & c.mem_write;
  assign MemLoad  = run & c.mem_load;
  assign RegWrite = run & c.reg_write;
  assign Halted   = run & c.halted;
  assign Trap     = run & c.trap;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: directed checks of the multi-cycle control FSM, default and 4-bit-opcode builds
module tb_controle_multiciclo;
  logic clock = 1'b0, reset_n = 1'b0, funct = 1'b0, memReady = 1'b0, resume = 1'b0;
  logic [2:0] opCode = 3'b000;
  logic [3:0] opCode4 = 4'b0000;
  logic IrWrite, PcWrite, Jump, Bnez, ULAsrc, MemWrite, MemLoad, RegWrite, Halted, Trap;
  logic [1:0] Reg1src, ULAop;
  logic IrWrite4, PcWrite4, Jump4, Bnez4, ULAsrc4, MemWrite4, MemLoad4, RegWrite4, Halted4, Trap4;
  logic [1:0] Reg1src4, ULAop4;
  logic [13:0] obs, obs4;
  int n_cmp = 0, n_bad = 0;
  localparam logic [13:0] IR = 14'h2000, PC = 14'h1000, R1_MEM = 14'h0800, R1_IMM = 14'h0400;
  localparam logic [13:0] JMP = 14'h0200, BNZ = 14'h0100, USRC = 14'h0080, UOP_SLT = 14'h0040;
  localparam logic [13:0] UOP_SUB = 14'h0020, MW = 14'h0010, ML = 14'h0008, RW = 14'h0004;
  localparam logic [13:0] HLT = 14'h0002, TRP = 14'h0001;
  assign obs  = {IrWrite, PcWrite, Reg1src, Jump, Bnez, ULAsrc, ULAop, MemWrite, MemLoad, RegWrite, Halted, Trap};
  assign obs4 = {IrWrite4, PcWrite4, Reg1src4, Jump4, Bnez4, ULAsrc4, ULAop4, MemWrite4, MemLoad4, RegWrite4, Halted4, Trap4};
  controle_multiciclo dut (
    .clock(clock), .reset_n(reset_n), .opCode(opCode), .funct(funct), .memReady(memReady), .resume(resume),
    .IrWrite(IrWrite), .PcWrite(PcWrite), .Reg1src(Reg1src), .Jump(Jump), .Bnez(Bnez), .ULAsrc(ULAsrc),
    .ULAop(ULAop), .MemWrite(MemWrite), .MemLoad(MemLoad), .RegWrite(RegWrite), .Halted(Halted), .Trap(Trap)
  );
  controle_multiciclo #(.OPCODE_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .opCode(opCode4), .funct(funct), .memReady(memReady), .resume(resume),
    .IrWrite(IrWrite4), .PcWrite(PcWrite4), .Reg1src(Reg1src4), .Jump(Jump4), .Bnez(Bnez4), .ULAsrc(ULAsrc4),
    .ULAop(ULAop4), .MemWrite(MemWrite4), .MemLoad(MemLoad4), .RegWrite(RegWrite4), .Halted(Halted4), .Trap(Trap4)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL reset_hold: got %b want %b", obs, 14'd0); end
    n_cmp++;
    if (obs4 !== 14'd0) begin n_bad++; $display("FAIL reset_hold4: got %b want %b", obs4, 14'd0); end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== IR) begin n_bad++; $display("FAIL reset_first_fetch: got %b want %b", obs, IR); end
  endtask
  task automatic test_alu();
    logic [2:0]  ops [4] = '{3'b000, 3'b000, 3'b001, 3'b110};
    logic        fns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [13:0] ex  [4] = '{14'd0, UOP_SUB, USRC, UOP_SLT};
    for (int k = 0; k < 4; k++) begin
      logic [13:0] s [4];
      s = '{IR, 14'd0, ex[k], RW | PC | ex[k]};
      opCode = ops[k];
      funct = fns[k];
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs !== s[i]) begin n_bad++; $display("FAIL alu op%0d cyc%0d: got %b want %b", k, i, obs, s[i]); end
        tick();
      end
    end
    funct = 1'b0;
  endtask
  task automatic test_setval();
    logic [13:0] s [3] = '{IR, 14'd0, RW | PC | R1_IMM};
    opCode = 3'b101;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== s[i]) begin n_bad++; $display("FAIL setval cyc%0d: got %b want %b", i, obs, s[i]); end
      tick();
    end
  endtask
  task automatic test_branch();
    logic [2:0]  ops [2] = '{3'b100, 3'b111};
    logic [13:0] ex  [2] = '{BNZ | PC, JMP | PC};
    resume = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [13:0] s [3];
      s = '{IR, 14'd0, ex[k]};
      opCode = ops[k];
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs !== s[i]) begin n_bad++; $display("FAIL branch op%0d cyc%0d: got %b want %b", k, i, obs, s[i]); end
        tick();
      end
    end
    resume = 1'b0;
  endtask
  task automatic test_lw();
    logic [13:0] m = IR | PC | R1_MEM | R1_IMM | RW | ML | MW;
    opCode = 3'b010;
    memReady = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs !== USRC) begin n_bad++; $display("FAIL lw_exec: got %b want %b", obs, USRC); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin memReady = 1'b1; #1; end
      n_cmp++;
      if (obs !== ML) begin n_bad++; $display("FAIL lw_mem%0d: got %b want %b", i, obs, ML); end
    end
    tick();
    memReady = 1'b0;
    #1;
    n_cmp++;
    if ((obs & m) !== (RW | PC | R1_MEM)) begin n_bad++; $display("FAIL lw_wb: got %b want %b", obs & m, RW | PC | R1_MEM); end
    tick();
    n_cmp++;
    if (obs !== IR) begin n_bad++; $display("FAIL lw_next_fetch: got %b want %b", obs, IR); end
  endtask
  task automatic test_sw();
    logic [13:0] s [5] = '{IR, 14'd0, USRC, MW | PC, IR};
    opCode = 3'b011;
    memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== s[i]) begin n_bad++; $display("FAIL sw cyc%0d: got %b want %b", i, obs, s[i]); end
      if (i < 4) tick();
    end
    memReady = 1'b0;
  endtask
  task automatic test_halt();
    opCode = 3'b111;
    funct = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs !== HLT) begin n_bad++; $display("FAIL halt_wait%0d: got %b want %b", i, obs, HLT); end
    end
    resume = 1'b1;
    #1;
    n_cmp++;
    if (obs !== (HLT | PC)) begin n_bad++; $display("FAIL halt_resume: got %b want %b", obs, HLT | PC); end
    tick();
    resume = 1'b0;
    funct = 1'b0;
    #1;
    n_cmp++;
    if (obs !== IR) begin n_bad++; $display("FAIL halt_exit_fetch: got %b want %b", obs, IR); end
  endtask
  task automatic test_midreset();
    opCode = 3'b000;
    funct = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs !== UOP_SUB) begin n_bad++; $display("FAIL midreset_exec: got %b want %b", obs, UOP_SUB); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL midreset_async: got %b want %b", obs, 14'd0); end
    tick();
    reset_n = 1'b1;
    tick();
    funct = 1'b0;
    n_cmp++;
    if (obs !== IR) begin n_bad++; $display("FAIL midreset_fetch: got %b want %b", obs, IR); end
  endtask
  task automatic test_timeout();
    int n_ml = 0;
    opCode = 3'b010;
    memReady = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (obs === ML) n_ml++;
    end
    n_cmp++;
    if (n_ml != 15) begin n_bad++; $display("FAIL timeout_mem_cycles: got %0d want %0d", n_ml, 15); end
    tick();
    n_cmp++;
    if (obs !== TRP) begin n_bad++; $display("FAIL timeout_trap: got %b want %b", obs, TRP); end
    resume = 1'b1;
    repeat (3) tick();
    resume = 1'b0;
    n_cmp++;
    if (obs !== TRP) begin n_bad++; $display("FAIL trap_sticky: got %b want %b", obs, TRP); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL trap_reset: got %b want %b", obs, 14'd0); end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== IR) begin n_bad++; $display("FAIL trap_reset_fetch: got %b want %b", obs, IR); end
  endtask
  task automatic test_illegal();
    logic [13:0] s [4] = '{IR, 14'd0, TRP, TRP};
    reset_n = 1'b0;
    tick();
    opCode4 = 4'b1000;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs4 !== s[i]) begin n_bad++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs4, s[i]); end
      tick();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_alu();
    test_setval();
    test_branch();
    test_lw();
    test_sw();
    test_halt();
    test_midreset();
    test_timeout();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
